// File: rtl/mux_rr_sel.sv
// rtl/mux_rr_sel.sv - round-robin burst arbiter driving the 4:1 mux select
module mux_rr_sel #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] req_i,
    input  logic       ready_i,
    output logic [1:0] direction_o,
    output logic       valid_o,
    output logic [3:0] ack_o,
    output logic       last_o
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] pick_off;
    logic       xfer;

    // Rotate requests so that bit 0 is the current priority holder.
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl[ptr_q +: 4];

    always_comb begin
        pick_off = 2'd0;
        if (req_rot[0])      pick_off = 2'd0;
        else if (req_rot[1]) pick_off = 2'd1;
        else if (req_rot[2]) pick_off = 2'd2;
        else if (req_rot[3]) pick_off = 2'd3;
    end

    // Outputs are gated by reset so nothing is acknowledged in a reset cycle.
    assign valid_o = rst_n_i && (state_q == GRANT) && req_i[direction_o];
    assign xfer    = valid_o && ready_i;
    assign ack_o   = xfer ? (4'b0001 << direction_o) : 4'b0000;
    assign last_o  = valid_o && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dir_d   = direction_o;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    dir_d   = ptr_q + pick_off;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req_i[direction_o]) begin
                    state_d = IDLE;
                    ptr_d   = direction_o + 2'd1;
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_o) begin
                        state_d = IDLE;
                        ptr_d   = direction_o + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= '0;
            direction_o <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            direction_o <= dir_d;
        end
    end

endmodule

// File: doc/mux_rr_sel.md
Name: mux_rr_sel

Overview:
- Upstream control stage for the 4:1, 2-bit `mux`: arbitrates among four source channels round-robin and drives the mux `direction_*` select.
- Holds the grant for a burst of up to BURST_LEN transfers, then moves priority to the next channel.
- Handshake with the consumer: valid_o/ready_i. Per-channel acknowledge back to the sources: ack_o.

Parameters:
- BURST_LEN, 4, max transfers per grant before forced re-arbitration; legal range 1..16.
- CNT_W, $clog2(BURST_LEN)+1, beat counter width; derived, not overridden.

Ports:
- clk_i  input  1  single clock, all state on rising edge
- rst_n_i  input  1  synchronous, active-low reset
- req_i  input  4  req_i[k]=1: channel k has a word on the mux data inputs; held until acked
- ready_i  input  1  consumer accepts the mux output this cycle
- direction_o  output  2  select to mux (bit0 -> direction_0_i, bit1 -> direction_1_i); registered
- valid_o  output  1  mux output holds a valid word from channel direction_o
- ack_o  output  4  one-hot; ack_o[k]=1 in the cycle channel k's word is transferred
- last_o  output  1  with valid_o: the current beat is the last of the burst

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - state=IDLE, ptr=0, beat_cnt=0, direction_o=2'b00.
  - valid_o, ack_o and last_o are 0 while reset is applied and in the first cycle after release.
  - Reset mid-burst aborts the burst. No ack is issued in the reset cycle.
- States: IDLE, GRANT.
- IDLE:
  - valid_o=0.
  - If |req_i, pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register it into direction_o, clear beat_cnt, go to GRANT.
  - Latency: req seen at edge N -> direction_o and valid_o valid after edge N+1.
- GRANT:
  - valid_o = req_i[direction_o] (combinational from req_i and registered state).
  - Transfer = valid_o & ready_i. On transfer: ack_o[direction_o]=1 that cycle; beat_cnt increments at the edge.
  - last_o = valid_o & (beat_cnt == BURST_LEN-1).
  - Transfer with last_o=1: next state IDLE, ptr = direction_o+1 (mod 4, wraps 3->0).
  - req_i[direction_o]=0 in GRANT (source emptied): next state IDLE, ptr = direction_o+1. No ack that cycle.
  - Otherwise stay in GRANT; direction_o is stable for the whole grant.
- Re-arbitration always passes through IDLE: one bubble cycle (valid_o=0) between grants.
- Requests from other channels during GRANT are ignored until the grant ends. No preemption.
- ready_i=0 stalls: direction_o, beat_cnt and last_o hold; ack_o=0.
- BURST_LEN=1: every transfer has last_o=1, giving strict per-word round-robin.
- ack_o is never asserted with valid_o=0. At most one ack_o bit is set per cycle.
- Source protocol: a channel holds req_i and its data until its ack; it may drop req_i in the cycle after the ack.
- No combinational path from ready_i to direction_o.

Test Plan:
- Reset then idle: rst_n_i=0 for 2 cycles, req_i=0 -> direction_o=00, valid_o=0, ack_o=0000, last_o=0 throughout.
- Single channel, BURST_LEN=4, req_i=0100 held, ready_i=1:
  - direction_o=10 one cycle after req.
  - 4 acks ack_o=0100; last_o=1 on the 4th.
  - Bubble cycle, then channel 2 is re-granted.
- Fairness, req_i=1111 constant, ready_i=1:
  - Grant order 00,01,10,11,00.
  - Each grant gives 4 acks followed by 1 bubble cycle.
  - ptr wrap 3->0 is checked.
- Stall: channel 1 granted, ready_i=0 for 3 cycles mid-burst -> valid_o=1, direction_o=01, ack_o=0000 held. Beat count resumes correctly when ready_i=1.
- Early release:
  - Channel 3 granted; req_i[3] drops after 2 acks -> IDLE, no 3rd ack.
  - With req_i=0011 pending, the next grant is channel 0 (ptr=0).
- Reset mid-burst: rst_n_i=0 during the 2nd beat of channel 2 -> next cycle valid_o=0, direction_o=00. After release, arbitration restarts from ptr=0.
